// File: rtl/instr_store_loadable_pkg.sv
// Shared definitions for the loadable instruction store.
// Contents: load FSM state encoding, the default NOP word, and a helper
// that derives how many bytes make up one instruction word.
package instr_store_loadable_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2
    } state_e;

    // Word fetched from unloaded or out-of-count addresses.
    localparam logic [27:0] INSTR_STORE_NOP = 28'h0;

    function automatic int unsigned bytes_per_word(input int unsigned width);
        return (width + 32'd7) / 32'd8;
    endfunction

endpackage

// File: rtl/instr_store_ram.sv
// Simple dual-port instruction RAM: one write port, one registered read port.
// Ports:
//   clk      in   clock, rising edge
//   wr_en    in   write enable
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address, sampled every cycle
//   rd_data  out  read data, one cycle after rd_addr is sampled
module instr_store_ram #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned INSTR_WIDTH = 28
) (
    input  logic                   clk,
    input  logic                   wr_en,
    input  logic [ADDR_WIDTH-1:0]  wr_addr,
    input  logic [INSTR_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [INSTR_WIDTH-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [INSTR_WIDTH-1:0] rd_data_d;
    logic [INSTR_WIDTH-1:0] rd_data_q;

    always_comb begin
        rd_data_d = mem[rd_addr];
    end

    // No reset on the array; stale contents are masked by the top.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/instr_store_loadable.sv
// Runtime-loadable instruction store. A byte stream (valid/ready) fills a
// RAM starting at address 0; the fetch port returns data one cycle after the
// address is sampled, or DEFAULT_INSTR for anything not yet validly loaded.
// Optional feature macro: INSTR_STORE_CHECKSUM_EN -- a trailing checksum word
// (XOR of all loaded words) must match before the program is declared valid.
// Ports:
//   Clock          in   clock, rising edge
//   Reset          in   asynchronous, active-high
//   iAddress       in   fetch address
//   oInstruction   out  fetch data, 1-cycle latency
//   iLoadStart     in   pulse: start loading iLoadCount words at address 0
//   iLoadCount     in   word count (1..DEPTH), sampled with iLoadStart
//   iByteData      in   load byte, little-endian within a word
//   iByteValid     in   load byte valid
//   oByteReady     out  load byte accepted when iByteValid & oByteReady
//   oProgramValid  out  program fully loaded
//   oLoadError     out  sticky bad count / checksum mismatch
module instr_store_loadable
    import instr_store_loadable_pkg::*;
#(
    parameter int unsigned            ADDR_WIDTH    = 8,
    parameter int unsigned            INSTR_WIDTH   = 28,
    parameter logic [INSTR_WIDTH-1:0] DEFAULT_INSTR = INSTR_WIDTH'(INSTR_STORE_NOP)
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [ADDR_WIDTH-1:0]  iAddress,
    output logic [INSTR_WIDTH-1:0] oInstruction,
    input  logic                   iLoadStart,
    input  logic [ADDR_WIDTH:0]    iLoadCount,
    input  logic [7:0]             iByteData,
    input  logic                   iByteValid,
    output logic                   oByteReady,
    output logic                   oProgramValid,
    output logic                   oLoadError
);

    localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
    localparam int unsigned BPW    = bytes_per_word(INSTR_WIDTH);
    localparam int unsigned ASM_W  = BPW * 8;
    localparam int unsigned BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned CNT_W  = ADDR_WIDTH + 1;

    state_e                 state_q, state_d;
    logic [BIDX_W-1:0]      byte_idx_q, byte_idx_d;
    logic [ASM_W-1:0]       asm_q, asm_d;
    logic [CNT_W-1:0]       loaded_q, loaded_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   prog_valid_q, prog_valid_d;
    logic                   load_error_q, load_error_d;
    logic                   byte_ready_q, byte_ready_d;
    logic                   fetch_ok_q, fetch_ok_d;
`ifdef INSTR_STORE_CHECKSUM_EN
    logic [INSTR_WIDTH-1:0] csum_q, csum_d;
`endif

    logic [ASM_W-1:0]       asm_ins_c;
    logic [INSTR_WIDTH-1:0] word_c;
    logic                   last_byte_c;
    logic                   byte_acc_c;
    logic                   count_ok_c;
    logic                   we_c;
    logic [INSTR_WIDTH-1:0] ram_rdata;

    // Load FSM, byte assembler, counters and fetch qualification.
    always_comb begin
        state_d      = state_q;
        byte_idx_d   = byte_idx_q;
        asm_d        = asm_q;
        loaded_d     = loaded_q;
        count_d      = count_q;
        prog_valid_d = prog_valid_q;
        load_error_d = load_error_q;
`ifdef INSTR_STORE_CHECKSUM_EN
        csum_d       = csum_q;
`endif
        we_c         = 1'b0;

        asm_ins_c = asm_q;
        asm_ins_c[8*int'(byte_idx_q) +: 8] = iByteData;
        // Padding bits above INSTR_WIDTH in the last byte are dropped here.
        word_c      = INSTR_WIDTH'(asm_ins_c);
        last_byte_c = (byte_idx_q == BIDX_W'(BPW - 1));
        byte_acc_c  = iByteValid && byte_ready_q;
        count_ok_c  = (iLoadCount != '0) && (iLoadCount <= CNT_W'(DEPTH));

        if (iLoadStart) begin
            if (count_ok_c) begin
                // Start or restart: any partial word is discarded.
                state_d      = ST_LOAD;
                count_d      = iLoadCount;
                byte_idx_d   = '0;
                loaded_d     = '0;
                prog_valid_d = 1'b0;
                load_error_d = 1'b0;
`ifdef INSTR_STORE_CHECKSUM_EN
                csum_d       = '0;
`endif
            end else begin
                load_error_d = 1'b1;
                // A bad restart still kills a load in progress.
                if (state_q != ST_IDLE) begin
                    state_d      = ST_IDLE;
                    byte_idx_d   = '0;
                    loaded_d     = '0;
                    prog_valid_d = 1'b0;
                end
            end
        end else if (byte_acc_c) begin
            asm_d      = asm_ins_c;
            byte_idx_d = last_byte_c ? '0 : BIDX_W'(byte_idx_q + 1'b1);
            case (state_q)
                ST_LOAD: begin
                    if (last_byte_c) begin
                        we_c     = 1'b1;
                        loaded_d = CNT_W'(loaded_q + 1'b1);
`ifdef INSTR_STORE_CHECKSUM_EN
                        csum_d   = csum_q ^ word_c;
`endif
                        if (CNT_W'(loaded_q + 1'b1) == count_q) begin
`ifdef INSTR_STORE_CHECKSUM_EN
                            state_d      = ST_CHECK;
`else
                            state_d      = ST_IDLE;
                            prog_valid_d = 1'b1;
`endif
                        end
                    end
                end
`ifdef INSTR_STORE_CHECKSUM_EN
                ST_CHECK: begin
                    if (last_byte_c) begin
                        state_d = ST_IDLE;
                        if (word_c == csum_q) begin
                            prog_valid_d = 1'b1;
                        end else begin
                            load_error_d = 1'b1;
                            loaded_d     = '0;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end

        byte_ready_d = (state_d != ST_IDLE);
        fetch_ok_d   = prog_valid_q && ({1'b0, iAddress} < loaded_q);
    end

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            loaded_q     <= '0;
            count_q      <= '0;
            prog_valid_q <= 1'b0;
            load_error_q <= 1'b0;
            byte_ready_q <= 1'b0;
            fetch_ok_q   <= 1'b0;
`ifdef INSTR_STORE_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            loaded_q     <= loaded_d;
            count_q      <= count_d;
            prog_valid_q <= prog_valid_d;
            load_error_q <= load_error_d;
            byte_ready_q <= byte_ready_d;
            fetch_ok_q   <= fetch_ok_d;
`ifdef INSTR_STORE_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    instr_store_ram #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_ram (
        .clk     (Clock),
        .wr_en   (we_c),
        .wr_addr (loaded_q[ADDR_WIDTH-1:0]),
        .wr_data (word_c),
        .rd_addr (iAddress),
        .rd_data (ram_rdata)
    );

    // Both select and data come straight from flops.
    assign oInstruction  = fetch_ok_q ? ram_rdata : DEFAULT_INSTR;
    assign oByteReady    = byte_ready_q;
    assign oProgramValid = prog_valid_q;
    assign oLoadError    = load_error_q;

endmodule

// File: tb/tb_instr_store_loadable.sv
module tb_instr_store_loadable;

    localparam logic [27:0] DEF = 28'hDEAD0F0;

    logic        Clock;
    logic        Reset;
    logic [7:0]  iAddress;
    logic [27:0] oInstruction;
    logic        iLoadStart;
    logic [8:0]  iLoadCount;
    logic [7:0]  iByteData;
    logic        iByteValid;
    logic        oByteReady;
    logic        oProgramValid;
    logic        oLoadError;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int          phase;
        logic [7:0]  addr;
        logic [27:0] exp;
    } fvec_t;

    fvec_t       ftab[$];
    logic [27:0] words [256];

    instr_store_loadable #(
        .ADDR_WIDTH    (8),
        .INSTR_WIDTH   (28),
        .DEFAULT_INSTR (DEF)
    ) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .iAddress      (iAddress),
        .oInstruction  (oInstruction),
        .iLoadStart    (iLoadStart),
        .iLoadCount    (iLoadCount),
        .iByteData     (iByteData),
        .iByteValid    (iByteValid),
        .oByteReady    (oByteReady),
        .oProgramValid (oProgramValid),
        .oLoadError    (oLoadError)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    function automatic logic [27:0] fdw(input int i);
        return {8'(i), 12'h5A5, 8'(255 - i)};
    endfunction

    function automatic void add(input int p, input logic [7:0] a, input logic [27:0] e);
        fvec_t v;
        v.phase = p;
        v.addr  = a;
        v.exp   = e;
        ftab.push_back(v);
    endfunction

    task automatic chk28(input string name, input logic [27:0] act, input logic [27:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic run_phase(input int p);
        foreach (ftab[i]) begin
            if (ftab[i].phase == p) begin
                iAddress = ftab[i].addr;
                tick();
                chk28($sformatf("fetch_p%0d_a%0d", p, ftab[i].addr), oInstruction, ftab[i].exp);
            end
        end
    endtask

    task automatic start_load(input logic [8:0] count);
        iLoadStart = 1'b1;
        iLoadCount = count;
        tick();
        iLoadStart = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        iByteData  = b;
        iByteValid = 1'b1;
        while (!oByteReady && n < 16) begin
            tick();
            n++;
        end
        if (!oByteReady) begin
            n_total++;
            $display("FAIL byte_ready_timeout: oByteReady stayed 0, required 1");
        end
        tick();
        iByteValid = 1'b0;
        repeat (gap) tick();
    endtask

    // Sends words[0..count-1] little-endian with junk in the padding nibble,
    // then (checksum build) the XOR word, optionally corrupted.
    task automatic load_prog(input int count, input int gap, input bit corrupt);
        logic [27:0] csum;
        logic [7:0]  bb;
        csum = '0;
        start_load(9'(count));
        for (int w = 0; w < count; w++) begin
            for (int b = 0; b < 4; b++) begin
                bb = 8'(words[w] >> (8 * b));
                if (b == 3) bb[7:4] = 4'hA;
                send_byte(bb, gap);
            end
            csum = csum ^ words[w];
        end
`ifdef INSTR_STORE_CHECKSUM_EN
        for (int b = 0; b < 4; b++) begin
            bb = 8'(csum >> (8 * b));
            if (b == 3) bb[7:4] = 4'hA;
            if (corrupt && b == 1) bb = bb ^ 8'h10;
            send_byte(bb, gap);
        end
`else
        if (corrupt) csum = '0;
`endif
    endtask

    initial begin
        Reset      = 1'b1;
        iAddress   = '0;
        iLoadStart = 1'b0;
        iLoadCount = '0;
        iByteData  = '0;
        iByteValid = 1'b0;

        // Fetch vectors per phase: {phase, address, expected instruction}.
        for (int a = 0; a < 4; a++) add(0, 8'(a), DEF);
        add(1, 8'd0, 28'h1000FA0);
        add(1, 8'd1, 28'h5070004);
        add(1, 8'd2, 28'h0000001);
        add(1, 8'd3, DEF);
        add(1, 8'd255, DEF);
        add(1, 8'd1, 28'h5070004);
        add(2, 8'd0, 28'h0ABC123);
        add(2, 8'd1, 28'hFFFFFFF);
        add(2, 8'd2, DEF);
        add(3, 8'd0, 28'h1234567);
        add(3, 8'd1, DEF);
        add(4, 8'd0, fdw(0));
        add(4, 8'd128, fdw(128));
        add(4, 8'd255, fdw(255));
        add(5, 8'd0, DEF);
        add(5, 8'd1, DEF);
        add(6, 8'd0, 28'h0123456);
        add(6, 8'd1, 28'h0FEDCBA);
        add(6, 8'd2, DEF);
        add(7, 8'd0, DEF);
        add(7, 8'd1, DEF);

        repeat (3) tick();
        chk28("reset_instr", oInstruction, DEF);
        Reset = 1'b0;
        tick();
        chk1("reset_ready", oByteReady, 1'b0);
        chk1("reset_valid", oProgramValid, 1'b0);
        chk1("reset_error", oLoadError, 1'b0);
        run_phase(0);

        // Three-word gapless load.
        words[0] = 28'h1000FA0;
        words[1] = 28'h5070004;
        words[2] = 28'h0000001;
        load_prog(3, 0, 1'b0);
        chk1("load3_ready_after", oByteReady, 1'b0);
        chk1("load3_valid", oProgramValid, 1'b1);
        // Bytes offered while idle must be ignored.
        iByteData  = 8'h55;
        iByteValid = 1'b1;
        repeat (3) tick();
        iByteValid = 1'b0;
        chk1("idle_bytes_valid", oProgramValid, 1'b1);
        chk1("idle_bytes_error", oLoadError, 1'b0);
        run_phase(1);

        // Two-word load with valid toggling every other cycle.
        words[0] = 28'h0ABC123;
        words[1] = 28'hFFFFFFF;
        start_load(9'd2);
        chk1("gap_ready_during", oByteReady, 1'b1);
        chk1("gap_valid_during", oProgramValid, 1'b0);
        load_prog(2, 1, 1'b0);
        chk1("gap_ready_after", oByteReady, 1'b0);
        chk1("gap_valid", oProgramValid, 1'b1);
        run_phase(2);

        // Bad counts.
        start_load(9'd0);
        chk1("cnt0_error", oLoadError, 1'b1);
        chk1("cnt0_idle", oByteReady, 1'b0);
        start_load(9'd257);
        chk1("cnt257_error", oLoadError, 1'b1);
        chk1("cnt257_idle", oByteReady, 1'b0);

        // Abort after 5 bytes of a 3-word load, then reload a single word.
        start_load(9'd3);
        chk1("restart_err_clear", oLoadError, 1'b0);
        chk1("restart_ready", oByteReady, 1'b1);
        chk1("restart_valid", oProgramValid, 1'b0);
        for (int k = 0; k < 5; k++) send_byte(8'(8'h11 * (k + 1)), 0);
        iAddress = 8'd0;
        tick();
        chk28("fetch_during_load", oInstruction, DEF);
        words[0] = 28'h1234567;
        load_prog(1, 0, 1'b0);
        chk1("abort_valid", oProgramValid, 1'b1);
        chk1("abort_ready_after", oByteReady, 1'b0);
        run_phase(3);

        // Full-depth load.
        for (int i = 0; i < 256; i++) words[i] = fdw(i);
        load_prog(256, 0, 1'b0);
        chk1("full_valid", oProgramValid, 1'b1);
        run_phase(4);

        // Reset in the middle of a load.
        start_load(9'd2);
        for (int k = 0; k < 3; k++) send_byte(8'(k + 1), 0);
        Reset = 1'b1;
        #1;
        chk1("midreset_ready", oByteReady, 1'b0);
        chk1("midreset_valid", oProgramValid, 1'b0);
        chk1("midreset_error", oLoadError, 1'b0);
        tick();
        Reset = 1'b0;
        tick();
        run_phase(5);

`ifdef INSTR_STORE_CHECKSUM_EN
        words[0] = 28'h0123456;
        words[1] = 28'h0FEDCBA;
        load_prog(2, 0, 1'b0);
        chk1("csum_ok_valid", oProgramValid, 1'b1);
        chk1("csum_ok_error", oLoadError, 1'b0);
        run_phase(6);
        load_prog(2, 0, 1'b1);
        chk1("csum_bad_error", oLoadError, 1'b1);
        chk1("csum_bad_valid", oProgramValid, 1'b0);
        run_phase(7);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
